// File: rtl/floo_pkg.sv
// Shared types for the floo router VC assignment logic.
package floo_pkg;

    typedef enum logic {
        VcStrict,
        VcFallback
    } vc_assign_mode_e;

    typedef enum logic {
        Unlocked,
        Locked
    } vc_lock_state_e;

endpackage

// File: rtl/floo_vc_credit_counter.sv
// Credit counter for one downstream VC buffer; saturates at Depth.
module floo_vc_credit_counter #(
    parameter int unsigned Depth    = 3,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                avail_o
);

    localparam logic [CntWidth-1:0] Full = CntWidth'(Depth);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= Full;
        end else if (inc_i && !dec_i && cnt_q != Full) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o   = cnt_q;
    assign avail_o = (cnt_q != '0);

    // Overflow is a downstream protocol slip that is survivable; underflow means broken assignment logic.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(inc_i && !dec_i && cnt_q == Full))
                else $warning("credit counter overflow, saturating at %0d", Depth);
            assert (!(dec_i && !inc_i && cnt_q == '0))
                else $error("credit counter underflow");
        end
    end

endmodule

// File: rtl/floo_vc_assignment_tracked.sv
// Per-output VC assignment with credit tracking, wormhole lock and optional
// round-robin fallback to any VC holding credit.
module floo_vc_assignment_tracked
    import floo_pkg::*;
#(
    parameter int unsigned     NumVC      = 4,
    parameter int unsigned     NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int unsigned     VcDepth    = 3,
    parameter int unsigned     CntWidth   = $clog2(VcDepth + 1),
    parameter vc_assign_mode_e Mode       = VcStrict
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sa_global_v_i,
    input  logic                  sa_global_last_i,
    input  logic [NumVCWidth-1:0] preferred_vc_id_i,
    input  logic                  require_correct_vc_i,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    output logic                  vc_assignment_v_o,
    output logic [NumVCWidth-1:0] vc_assignment_id_o,
    output logic [NumVC-1:0]      vc_credit_avail_o,
    output logic                  vc_locked_o,
    output logic [NumVCWidth-1:0] vc_locked_id_o
);

    localparam logic [NumVCWidth:0] NumVCExt = (NumVCWidth + 1)'(NumVC);

    logic [CntWidth-1:0]   cnt [NumVC];
    logic [NumVC-1:0]      cnt_avail;
    logic [NumVC-1:0]      avail_eff;
    logic [NumVCWidth-1:0] pref_idx;

    vc_lock_state_e        state_q;
    logic [NumVCWidth-1:0] locked_id_q;

    logic                  sel_v;
    logic [NumVCWidth-1:0] sel_id;
    logic                  fb_fire;
    logic                  fb_found;
    logic [NumVCWidth-1:0] fb_id;

    assign pref_idx = (NumVC > 1) ? preferred_vc_id_i : '0;

    for (genvar v = 0; v < NumVC; v++) begin : gen_cnt
        floo_vc_credit_counter #(
            .Depth    (VcDepth),
            .CntWidth (CntWidth)
        ) i_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (credit_v_i && credit_id_i == NumVCWidth'(v)),
            .dec_i   (sel_v && sel_id == NumVCWidth'(v)),
            .cnt_o   (cnt[v]),
            .avail_o (cnt_avail[v])
        );
    end

    // A credit returning this cycle may be spent immediately.
    always_comb begin
        avail_eff = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            avail_eff[v] = cnt_avail[v] | (credit_v_i && credit_id_i == NumVCWidth'(v));
        end
    end

    if (NumVC > 1) begin : gen_fb
        logic [NumVC-1:0]      cand;
        logic [2*NumVC-1:0]    dbl;
        logic [NumVCWidth-1:0] rr_q;

        // Rotating the doubled vector by rr turns the cyclic search into a plain priority pick.
        always_comb begin
            cand = avail_eff;
            cand[pref_idx] = 1'b0;
            dbl = {cand, cand} >> rr_q;
            fb_found = 1'b0;
            fb_id = '0;
            for (int unsigned k = 0; k < NumVC; k++) begin
                if (!fb_found && dbl[k]) begin
                    fb_found = 1'b1;
                    fb_id = NumVCWidth'((32'(rr_q) + k) % NumVC);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_q <= '0;
            end else if (fb_fire) begin
                rr_q <= (fb_id == NumVCWidth'(NumVC - 1)) ? '0 : fb_id + 1'b1;
            end
        end
    end else begin : gen_no_fb
        assign fb_found = 1'b0;
        assign fb_id    = '0;
    end

    always_comb begin
        sel_v   = 1'b0;
        sel_id  = '0;
        fb_fire = 1'b0;
        if (rst_ni && sa_global_v_i) begin
            if (state_q == Locked) begin
                sel_id = locked_id_q;
                sel_v  = avail_eff[locked_id_q];
            end else if (avail_eff[pref_idx]) begin
                sel_v  = 1'b1;
                sel_id = pref_idx;
            end else if (Mode == VcFallback && !require_correct_vc_i && fb_found) begin
                sel_v   = 1'b1;
                sel_id  = fb_id;
                fb_fire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Unlocked;
            locked_id_q <= '0;
        end else if (sel_v) begin
            case (state_q)
                Unlocked: begin
                    if (!sa_global_last_i) begin
                        state_q     <= Locked;
                        locked_id_q <= sel_id;
                    end
                end
                Locked: begin
                    if (sa_global_last_i) begin
                        state_q     <= Unlocked;
                        locked_id_q <= '0;
                    end
                end
                default: state_q <= Unlocked;
            endcase
        end
    end

    assign vc_assignment_v_o  = sel_v;
    assign vc_assignment_id_o = sel_id;
    assign vc_credit_avail_o  = cnt_avail;
    assign vc_locked_o        = (state_q == Locked);
    assign vc_locked_id_o     = locked_id_q;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (sa_global_v_i) begin
                assert ({1'b0, preferred_vc_id_i} < NumVCExt)
                    else $error("preferred VC id %0d out of range", preferred_vc_id_i);
            end
            if (credit_v_i) begin
                assert ({1'b0, credit_id_i} < NumVCExt)
                    else $error("credit VC id %0d out of range", credit_id_i);
            end
            for (int unsigned v = 0; v < NumVC; v++) begin
                assert (cnt_avail[v] == (cnt[v] != '0))
                    else $error("credit availability inconsistent on VC %0d", v);
            end
        end
    end

endmodule

// File: tb/tb_floo_vc_assignment_tracked.sv
// Directed bench: one strict and one fallback instance fed identical stimulus.
module tb_floo_vc_assignment_tracked;
    import floo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sa_v, last, req, cv;
    logic [1:0] pref, cid;

    logic       s_v, s_lk, f_v, f_lk;
    logic [1:0] s_id, s_lkid, f_id, f_lkid;
    logic [3:0] s_avail, f_avail;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    floo_vc_assignment_tracked #(
        .NumVC   (4),
        .VcDepth (3),
        .Mode    (VcStrict)
    ) dut_s (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .sa_global_v_i        (sa_v),
        .sa_global_last_i     (last),
        .preferred_vc_id_i    (pref),
        .require_correct_vc_i (req),
        .credit_v_i           (cv),
        .credit_id_i          (cid),
        .vc_assignment_v_o    (s_v),
        .vc_assignment_id_o   (s_id),
        .vc_credit_avail_o    (s_avail),
        .vc_locked_o          (s_lk),
        .vc_locked_id_o       (s_lkid)
    );

    floo_vc_assignment_tracked #(
        .NumVC   (4),
        .VcDepth (3),
        .Mode    (VcFallback)
    ) dut_f (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .sa_global_v_i        (sa_v),
        .sa_global_last_i     (last),
        .preferred_vc_id_i    (pref),
        .require_correct_vc_i (req),
        .credit_v_i           (cv),
        .credit_id_i          (cid),
        .vc_assignment_v_o    (f_v),
        .vc_assignment_id_o   (f_id),
        .vc_credit_avail_o    (f_avail),
        .vc_locked_o          (f_lk),
        .vc_locked_id_o       (f_lkid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after a falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic v, input logic l, input logic [1:0] p,
                         input logic r, input logic c, input logic [1:0] ci);
        sa_v = v; last = l; pref = p; req = r; cv = c; cid = ci;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 2, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_v", s_v, 0);
        check("rst_id", s_id, 0);
        check("rst_avail", s_avail, 4'b1111);
        check("rst_lk", s_lk, 0);
        check("rst_lkid", s_lkid, 0);
        check("rst_f_v", f_v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // exhaustion of VC2
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2, 0, 0, 0);
            check("exh_s_v", s_v, 1);
            check("exh_s_id", s_id, 2);
            check("exh_f_id", f_id, 2);
            tick();
        end
        drive(1, 1, 2, 0, 0, 0);
        check("exh4_s_v", s_v, 0);
        check("exh4_s_id", s_id, 0);
        check("exh4_f_v", f_v, 1);
        check("exh4_f_id", f_id, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("idle_s_v", s_v, 0);
        check("exh_s_avail", s_avail, 4'b1011);
        check("exh_f_avail", f_avail, 4'b1011);

        // credit shortcut
        drive(1, 1, 2, 0, 1, 2);
        check("sc_s_v", s_v, 1);
        check("sc_s_id", s_id, 2);
        check("sc_f_id", f_id, 2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("sc_s_avail", s_avail, 4'b1011);

        // fallback with VC1 exhausted
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            check("fb_pre_id", f_id, 1);
            tick();
        end
        drive(1, 1, 1, 0, 0, 0);
        check("fb1_s_v", s_v, 0);
        check("fb1_f_v", f_v, 1);
        check("fb1_f_id", f_id, 0);
        tick();
        drive(1, 1, 1, 0, 0, 0);
        check("fb2_f_v", f_v, 1);
        check("fb2_f_id", f_id, 2);
        tick();
        drive(1, 1, 1, 1, 0, 0);
        check("fb_req_f_v", f_v, 0);
        check("fb_req_f_id", f_id, 0);
        tick();

        // wormhole lock
        do_reset();
        drive(1, 0, 3, 0, 0, 0);
        check("wh_head_v", s_v, 1);
        check("wh_head_id", s_id, 3);
        check("wh_head_lk", s_lk, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        check("wh_lk", s_lk, 1);
        check("wh_lkid", s_lkid, 3);
        check("wh_body_id", s_id, 3);
        check("wh_body_v", s_v, 1);
        check("wh_body_f_id", f_id, 3);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        check("wh_tail_id", s_id, 3);
        check("wh_tail_v", s_v, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("wh_unlk", s_lk, 0);
        check("wh_unlk_id", s_lkid, 0);
        check("wh_avail", s_avail, 4'b0111);

        // lock stall on empty VC3
        drive(1, 0, 3, 0, 1, 3);
        check("st_head_v", s_v, 1);
        check("st_head_id", s_id, 3);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        check("st_s_v", s_v, 0);
        check("st_s_id", s_id, 3);
        check("st_lk", s_lk, 1);
        check("st_f_v", f_v, 0);
        tick();
        drive(1, 0, 0, 0, 1, 3);
        check("st_cr_s_v", s_v, 1);
        check("st_cr_s_id", s_id, 3);
        check("st_cr_f_v", f_v, 1);
        tick();

        // asynchronous reset mid-packet
        drive(0, 0, 0, 0, 0, 0);
        check("mid_lk_before", s_lk, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_lk", s_lk, 0);
        check("mid_lkid", s_lkid, 0);
        check("mid_s_avail", s_avail, 4'b1111);
        check("mid_f_avail", f_avail, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // credit into a full VC saturates
        drive(0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            check("ovf_s_v", s_v, 1);
            check("ovf_s_id", s_id, 0);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0);
        check("ovf4_s_v", s_v, 0);
        check("ovf4_f_v", f_v, 1);
        check("ovf4_f_id", f_id, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
